// File: rtl/phy_pkg.sv
// Shared lane definitions for the serial PHY transmitter and receiver.
// Both ends import this so they agree on symbol width and the comma byte.
package phy_pkg;

  localparam int         DATA_W       = 8;
  localparam logic [7:0] IDLE_PATTERN = 8'hBC;
  localparam int         LOCK_COUNT   = 4;

  typedef enum logic [0:0] {
    INIT   = 1'b0,
    ACTIVE = 1'b1
  } phy_rx_state_t;

endpackage

// File: rtl/phy_rx_serial_lane_if.sv
// Per-lane receive bundle: serial bit in, rebuilt byte, flags out.
// master = side feeding the serial stream, slave = the receiver lane.
interface phy_rx_serial_lane_if #(
  parameter int DATA_W = 8
);

  logic              data_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              active;
  logic              byte_strobe;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  byte_strobe
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active,
    output byte_strobe
  );

endinterface

// File: rtl/phy_rx_comma_detect.sv
// Serial shift register and comma comparator for one receive lane.
// With PHY_RX_RELOCK_EN defined it also tracks commas that land off the
// current byte boundary, so the lane can re-phase after a bit slip.
module phy_rx_comma_detect #(
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] IDLE_PATTERN = 8'hBC,
  parameter int                CW           = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_data_in,
`ifdef PHY_RX_RELOCK_EN
  input  logic              i_track_en,
  input  logic [CW-1:0]     i_bit_cnt,
  input  logic              i_boundary,
  input  logic              i_rephase,
  output logic              o_slot_seen,
  output logic              o_same_off,
  output logic [CW-1:0]     o_slot_off,
`endif
  output logic [DATA_W-1:0] o_shreg_next,
  output logic              o_match
);

  logic [DATA_W-1:0] r_shreg;

  // The byte is judged on the same edge its last bit arrives.
  assign o_shreg_next = {r_shreg[DATA_W-2:0], i_data_in};
  assign o_match      = (o_shreg_next == IDLE_PATTERN);

  // Shift one bit in per clock, MSB first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
    end else begin
      r_shreg <= o_shreg_next;
    end
  end

`ifdef PHY_RX_RELOCK_EN
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  logic          w_off_hit;
  logic          r_seen;
  logic          r_prev_seen;
  logic [CW-1:0] r_off;
  logic [CW-1:0] r_prev_off;

  // A comma completing on any edge other than the boundary edge.
  assign w_off_hit = i_track_en && o_match && (i_bit_cnt != LAST_BIT);

  // Remember the off-boundary comma offset for this slot and the previous one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen      <= 1'b0;
      r_prev_seen <= 1'b0;
      r_off       <= '0;
      r_prev_off  <= '0;
    end else if (!i_track_en) begin
      r_seen      <= 1'b0;
      r_prev_seen <= 1'b0;
      r_off       <= '0;
      r_prev_off  <= '0;
    end else if (i_boundary) begin
      // after a re-phase the old history no longer describes the new grid
      r_prev_seen <= r_seen && !i_rephase;
      r_prev_off  <= r_off;
      r_seen      <= 1'b0;
    end else if (w_off_hit) begin
      r_seen <= 1'b1;
      r_off  <= i_bit_cnt;
    end
  end

  // The boundary edge itself can never be an off-boundary hit, so the
  // registered slot state is complete when the boundary is evaluated.
  assign o_slot_seen = r_seen;
  assign o_same_off  = r_seen && r_prev_seen && (r_off == r_prev_off);
  assign o_slot_off  = r_off;
`endif

endmodule

// File: rtl/phy_rx_serial_lane.sv
// Per-lane serial-to-parallel receiver. Locks byte alignment on a run of
// comma bytes, then rebuilds one byte per DATA_W clocks with a valid flag.
// Optional build macro: PHY_RX_RELOCK_EN (re-phase the byte grid after a
// persistent off-boundary comma while staying ACTIVE).
module phy_rx_serial_lane #(
  parameter int                DATA_W       = phy_pkg::DATA_W,
  parameter logic [DATA_W-1:0] IDLE_PATTERN = phy_pkg::IDLE_PATTERN,
  parameter int                LOCK_COUNT   = phy_pkg::LOCK_COUNT
) (
  input  logic               clk_8f,
  input  logic               reset,
  phy_rx_serial_lane_if.slave lane
);

  import phy_pkg::*;

  localparam int            CW       = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic [CW-1:0] ONE_BIT  = CW'(1);
  localparam logic [3:0]    LOCK_TGT = 4'(LOCK_COUNT);

  phy_rx_state_t     r_state;
  logic [CW-1:0]     r_bit_cnt;
  logic [3:0]        r_bc_cnt;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_active;
  logic              r_byte_strobe;

  logic [DATA_W-1:0] w_shreg_next;
  logic              w_match;
  logic              w_aligned;
  logic              w_boundary;
  logic [3:0]        w_bc_inc;
  logic [CW-1:0]     w_bit_cnt_inc;

`ifdef PHY_RX_RELOCK_EN
  logic              w_slot_seen;
  logic              w_same_off;
  logic [CW-1:0]     w_slot_off;
  logic [3:0]        r_slip_cnt;
  logic [3:0]        w_slip_next;
  logic              w_rephase;
  logic [CW-1:0]     w_rephase_cnt;
`endif

  phy_rx_comma_detect #(
    .DATA_W       (DATA_W),
    .IDLE_PATTERN (IDLE_PATTERN),
    .CW           (CW)
  ) u_comma_detect (
    .clk          (clk_8f),
    .rst_n        (reset),
    .i_data_in    (lane.data_in),
`ifdef PHY_RX_RELOCK_EN
    .i_track_en   (r_state == ACTIVE),
    .i_bit_cnt    (r_bit_cnt),
    .i_boundary   (w_boundary),
    .i_rephase    (w_rephase),
    .o_slot_seen  (w_slot_seen),
    .o_same_off   (w_same_off),
    .o_slot_off   (w_slot_off),
`endif
    .o_shreg_next (w_shreg_next),
    .o_match      (w_match)
  );

  // While searching (INIT, no candidate) any comma match is a boundary;
  // once a candidate exists the boundary is every DATA_W-th edge.
  assign w_aligned     = (r_state == ACTIVE) || (r_bc_cnt != 4'd0);
  assign w_boundary    = w_aligned ? (r_bit_cnt == LAST_BIT) : w_match;
  assign w_bc_inc      = r_bc_cnt + 4'd1;
  assign w_bit_cnt_inc = (r_bit_cnt == LAST_BIT) ? '0 : (r_bit_cnt + ONE_BIT);

`ifdef PHY_RX_RELOCK_EN
  // Count consecutive slots whose off-boundary comma sits at the same offset
  always_comb begin
    w_slip_next = 4'd0;
    if (w_slot_seen) begin
      if (w_same_off) begin
        w_slip_next = r_slip_cnt + 4'd1;
      end else begin
        w_slip_next = 4'd1;
      end
    end else begin
      w_slip_next = 4'd0;
    end
  end

  assign w_rephase     = (r_state == ACTIVE) && w_boundary && (w_slip_next == LOCK_TGT);
  // Load the counter so the next boundary lands DATA_W edges after the comma.
  assign w_rephase_cnt = LAST_BIT - w_slot_off;

  // Slip counter advances only on boundaries while locked
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      r_slip_cnt <= 4'd0;
    end else if (r_state != ACTIVE) begin
      r_slip_cnt <= 4'd0;
    end else if (w_boundary) begin
      r_slip_cnt <= w_rephase ? 4'd0 : w_slip_next;
    end
  end
`endif

  // Lock FSM, alignment counters and registered lane outputs
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      r_state       <= INIT;
      r_bit_cnt     <= '0;
      r_bc_cnt      <= 4'd0;
      r_data_out    <= '0;
      r_valid_out   <= 1'b0;
      r_active      <= 1'b0;
      r_byte_strobe <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_byte_strobe <= 1'b0;
          r_bit_cnt     <= w_aligned ? w_bit_cnt_inc : '0;
          if (w_boundary) begin
            if (w_match) begin
              r_bc_cnt <= w_bc_inc;
              if (w_bc_inc == LOCK_TGT) begin
                r_state       <= ACTIVE;
                r_active      <= 1'b1;
                r_byte_strobe <= 1'b1;
                r_valid_out   <= 1'b0;
              end
            end else begin
              // candidate broken: resume bit search on the next edge
              r_bc_cnt <= 4'd0;
            end
          end
        end
        ACTIVE: begin
          r_bit_cnt <= w_bit_cnt_inc;
          if (w_boundary) begin
            r_byte_strobe <= 1'b1;
`ifdef PHY_RX_RELOCK_EN
            if (w_rephase) begin
              r_bit_cnt   <= w_rephase_cnt;
              r_valid_out <= 1'b0;
            end else if (!w_match) begin
`else
            if (!w_match) begin
`endif
              r_data_out  <= w_shreg_next;
              r_valid_out <= 1'b1;
            end else begin
              // idle slot: payload equal to the comma is indistinguishable
              r_valid_out <= 1'b0;
            end
          end else begin
            r_byte_strobe <= 1'b0;
          end
        end
        default: begin
          r_state       <= INIT;
          r_bc_cnt      <= 4'd0;
          r_byte_strobe <= 1'b0;
        end
      endcase
    end
  end

  assign lane.data_out    = r_data_out;
  assign lane.valid_out   = r_valid_out;
  assign lane.active      = r_active;
  assign lane.byte_strobe = r_byte_strobe;

endmodule

// File: tb/tb_phy_rx_serial_lane.sv
// Directed bench for phy_rx_serial_lane. Byte-slot results are queued
// (with the clock cycle they must appear on) when stimulus is driven and
// checked by a strobe monitor; level checks are made inline.
module tb_phy_rx_serial_lane;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic        valid;
  } exp_t;

  logic        clk_8f = 1'b0;
  logic        reset;
  int unsigned cyc    = 0;
  int          n_cmp  = 0;
  int          n_err  = 0;
  exp_t        sb[$];
  exp_t        e;
  int unsigned base;

  phy_rx_serial_lane_if #(.DATA_W(8)) lane ();

  phy_rx_serial_lane dut (
    .clk_8f (clk_8f),
    .reset  (reset),
    .lane   (lane)
  );

  always #5 clk_8f = ~clk_8f;

  always @(posedge clk_8f) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned c, input logic [7:0] d, input logic v);
    exp_t x;
    x.cyc   = c;
    x.data  = d;
    x.valid = v;
    sb.push_back(x);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_8f);
    lane.data_in = b;
  endtask

  // Drive one byte MSB first; optionally expect a strobe on its last bit edge.
  task automatic send_byte(input logic [7:0] b, input logic exp_en,
                           input logic [7:0] ed, input logic ev);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    if (exp_en) push(cyc + 1, ed, ev);
  endtask

  task automatic after_edge();
    @(posedge clk_8f);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_8f);
    #1;
    reset        = 1'b0;
    lane.data_in = 1'b0;
    repeat (2) @(negedge clk_8f);
    reset = 1'b1;
  endtask

  // Strobe monitor: every strobe must match the oldest queued slot result
  always @(negedge clk_8f) begin
    if (lane.byte_strobe === 1'b1) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL strobe_unexpected: observed strobe at cycle %0d, expected none", cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("strobe_cycle", 32'(cyc), 32'(e.cyc));
        check("slot_data_out", 32'(lane.data_out), 32'(e.data));
        check("slot_valid_out", 32'(lane.valid_out), 32'(e.valid));
      end
    end
  end

  initial begin
    reset        = 1'b0;
    lane.data_in = 1'b0;

    // reset state
    repeat (3) @(negedge clk_8f);
    check("rst_data_out", 32'(lane.data_out), 32'h0);
    check("rst_valid_out", 32'(lane.valid_out), 32'h0);
    check("rst_active", 32'(lane.active), 32'h0);
    check("rst_byte_strobe", 32'(lane.byte_strobe), 32'h0);
    reset = 1'b1;

    // lock on four commas
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    after_edge();
    check("lock_not_yet", 32'(lane.active), 32'h0);
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
    after_edge();
    check("lock_active", 32'(lane.active), 32'h1);

    // payload with an embedded idle slot
    send_byte(8'h24, 1'b1, 8'h24, 1'b1);
    send_byte(8'h81, 1'b1, 8'h81, 1'b1);
    send_byte(8'hBC, 1'b1, 8'h81, 1'b0);
    send_byte(8'h09, 1'b1, 8'h09, 1'b1);
    after_edge();
    check("pre_reset_valid", 32'(lane.valid_out), 32'h1);

    // asynchronous reset mid-byte while ACTIVE
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk_8f);
    #2;
    reset        = 1'b0;
    lane.data_in = 1'b0;
    #1;
    check("async_data_out", 32'(lane.data_out), 32'h0);
    check("async_valid_out", 32'(lane.valid_out), 32'h0);
    check("async_active", 32'(lane.active), 32'h0);
    check("async_byte_strobe", 32'(lane.byte_strobe), 32'h0);
    @(negedge clk_8f);
    @(negedge clk_8f);
    reset = 1'b1;

    // two junk bits, then lock at offset 2 needing four fresh commas
    send_bit(1'b1);
    send_bit(1'b1);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    after_edge();
    check("relock_not_yet", 32'(lane.active), 32'h0);
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
    send_byte(8'h63, 1'b1, 8'h63, 1'b1);
    after_edge();
    check("offset2_data_out", 32'(lane.data_out), 32'h63);

    // broken candidate: three commas, a non-idle byte, then a full run
    do_reset();
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'h0D, 1'b0, 8'h00, 1'b0);
    after_edge();
    check("false_no_lock", 32'(lane.active), 32'h0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    after_edge();
    check("second_run_not_yet", 32'(lane.active), 32'h0);
    send_byte(8'hBC, 1'b1, 8'h00, 1'b0);
    base = cyc + 1;
    after_edge();
    check("second_run_lock", 32'(lane.active), 32'h1);

    // 3-bit slip after lock, then four commas, 0x5A, 0x3C
    push(base + 8,  8'h17, 1'b1);
    push(base + 16, 8'h97, 1'b1);
    push(base + 24, 8'h97, 1'b1);
    push(base + 32, 8'h97, 1'b1);
`ifdef PHY_RX_RELOCK_EN
    push(base + 40, 8'h97, 1'b0);
    push(base + 43, 8'h5A, 1'b1);
    push(base + 51, 8'h3C, 1'b1);
`else
    push(base + 40, 8'h8B, 1'b1);
    push(base + 48, 8'h47, 1'b1);
`endif
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
    send_byte(8'h5A, 1'b0, 8'h00, 1'b0);
    send_byte(8'h3C, 1'b0, 8'h00, 1'b0);
    after_edge();
    check("slip_active_held", 32'(lane.active), 32'h1);
`ifdef PHY_RX_RELOCK_EN
    check("slip_data_out", 32'(lane.data_out), 32'h3C);
`else
    check("slip_data_out", 32'(lane.data_out), 32'h47);
`endif
    do_reset();
    repeat (2) @(negedge clk_8f);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
